// File: rtl/mem_wb_pipe_reg_pkg.sv
// mips_pkg: shared definitions for the MEM->WB pipeline register.
//   MIPS_DATA_W / MIPS_REG_AW : default datapath and register-address widths
//   wb_payload_t              : one MEM->WB instruction record
//   occ_state_e               : holding-register state, encoded as its occupancy
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_REG_AW = 5;

  typedef struct packed {
    logic [MIPS_DATA_W-1:0] aluresult;
    logic [MIPS_DATA_W-1:0] memread;
    logic [MIPS_REG_AW-1:0] writereg;
    logic                   memtoreg;
    logic                   regwrite;
  } wb_payload_t;

  // The encoding equals the number of held entries.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// mem_wb_pipe_reg_if: MEM-side and WB-side handshake bundle of the MEM/WB register.
//   mem_* : MEM stage offers one instruction (valid/ready plus payload)
//   wb_*  : pipeline register presents the oldest held instruction to write-back
//   master : the surrounding pipeline (drives mem_* payload/valid and wb_ready)
//   slave  : the pipeline register itself
interface mem_wb_pipe_reg_if
  import mips_pkg::*;
#(
  parameter int DATA_W = MIPS_DATA_W,
  parameter int REG_AW = MIPS_REG_AW
);

  logic              mem_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_aluresult;
  logic [DATA_W-1:0] mem_memread;
  logic [REG_AW-1:0] mem_writereg;
  logic              mem_memtoreg;
  logic              mem_regwrite;

  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] wb_writereg;
  logic              wb_regwrite;
  logic [DATA_W-1:0] wb_result;

  modport master (
    output mem_valid, mem_aluresult, mem_memread, mem_writereg, mem_memtoreg, mem_regwrite,
    output wb_ready,
    input  mem_ready, wb_valid, wb_writereg, wb_regwrite, wb_result
  );

  modport slave (
    input  mem_valid, mem_aluresult, mem_memread, mem_writereg, mem_memtoreg, mem_regwrite,
    input  wb_ready,
    output mem_ready, wb_valid, wb_writereg, wb_regwrite, wb_result
  );

endinterface

// File: rtl/mem_wb_pipe_reg_skid_buf.sv
// pipe_skid_buf: generic 2-entry valid/ready holding register with flush.
//   in_*        : upstream handshake and payload
//   out_*       : oldest entry (main) and downstream handshake
//   skid_*      : younger entry, exposed for lookups
//   occupancy_o : number of held entries (0..2)
// With SKID_EN=1 in_ready_o depends on registered state only; with SKID_EN=0
// the skid entry is never used and in_ready_o passes out_ready_i through.
module pipe_skid_buf
  import mips_pkg::*;
#(
  parameter type T       = wb_payload_t,
  parameter bit  SKID_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  T           in_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output T           out_data_o,
  output logic       skid_valid_o,
  output T           skid_data_o,
  output logic [1:0] occupancy_o
);

  occ_state_e state_q, state_d;
  T           main_q, main_d;
  T           skid_q, skid_d;
  logic       main_valid_s;
  logic       skid_valid_s;
  logic       accept_s;
  logic       pop_s;

  assign main_valid_s = (state_q != OCC_EMPTY);
  assign skid_valid_s = (state_q == OCC_FULL);
  assign in_ready_o   = SKID_EN ? ~skid_valid_s : (~main_valid_s | out_ready_i);
  assign accept_s     = in_valid_i & in_ready_o & ~flush_i;
  assign pop_s        = main_valid_s & out_ready_i;

  assign out_valid_o  = main_valid_s;
  assign out_data_o   = main_q;
  assign skid_valid_o = skid_valid_s;
  assign skid_data_o  = skid_q;
  assign occupancy_o  = {1'b0, main_valid_s} + {1'b0, skid_valid_s};

  // State and payload registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state: main always holds the older entry, skid the younger one.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = OCC_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept_s) begin
            state_d = OCC_ONE;
            main_d  = in_data_i;
          end else begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept_s && pop_s) begin
            main_d = in_data_i;
          end else if (accept_s && SKID_EN) begin
            state_d = OCC_FULL;
            skid_d  = in_data_i;
          end else if (pop_s) begin
            state_d = OCC_EMPTY;
          end else begin
            state_d = OCC_ONE;
          end
        end
        OCC_FULL: begin
          // in_ready_o is low here, so only a pop can happen.
          if (pop_s) begin
            state_d = OCC_ONE;
            main_d  = skid_q;
          end else begin
            state_d = OCC_FULL;
          end
        end
        default: begin
          state_d = OCC_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM->WB pipeline register with valid/ready handshake,
// 2-entry skid buffer, flush and a forwarding lookup port.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   flush_i     : drop held entries and this cycle's incoming transfer
//   bus         : mem_* input handshake/payload, wb_* output handshake/result
//   fwd_rs_i    : register address looked up against held entries
//   fwd_hit_o   : a valid held entry writes fwd_rs_i
//   fwd_data_o  : result of the youngest matching entry, 0 on miss
//   occupancy_o : number of held entries
module mem_wb_pipe_reg
  import mips_pkg::*;
#(
  parameter int DATA_W  = MIPS_DATA_W,
  parameter int REG_AW  = MIPS_REG_AW,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  mem_wb_pipe_reg_if.slave  bus,
  input  logic [REG_AW-1:0] fwd_rs_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [1:0]        occupancy_o
);

  typedef struct packed {
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] memread;
    logic [REG_AW-1:0] writereg;
    logic              memtoreg;
    logic              regwrite;
  } payload_t;

  function automatic logic [DATA_W-1:0] select_result(input payload_t p);
    return p.memtoreg ? p.memread : p.aluresult;
  endfunction

  payload_t in_s, main_s, skid_s;
  logic     main_valid_s;
  logic     skid_valid_s;
  logic     rs_nonzero_s;
  logic     main_hit_s;
  logic     skid_hit_s;

  // Pack the incoming record; writes to $0 are turned into no-ops here so
  // they can never reach the register file or the forwarding path.
  always_comb begin
    in_s.aluresult = bus.mem_aluresult;
    in_s.memread   = bus.mem_memread;
    in_s.writereg  = bus.mem_writereg;
    in_s.memtoreg  = bus.mem_memtoreg;
    in_s.regwrite  = bus.mem_regwrite & (bus.mem_writereg != {REG_AW{1'b0}});
  end

  pipe_skid_buf #(
    .T       (payload_t),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .in_valid_i   (bus.mem_valid),
    .in_ready_o   (bus.mem_ready),
    .in_data_i    (in_s),
    .out_valid_o  (main_valid_s),
    .out_ready_i  (bus.wb_ready),
    .out_data_o   (main_s),
    .skid_valid_o (skid_valid_s),
    .skid_data_o  (skid_s),
    .occupancy_o  (occupancy_o)
  );

  assign bus.wb_valid    = main_valid_s;
  assign bus.wb_regwrite = main_valid_s & main_s.regwrite;
  assign bus.wb_writereg = main_valid_s ? main_s.writereg : {REG_AW{1'b0}};
  assign bus.wb_result   = main_valid_s ? select_result(main_s) : {DATA_W{1'b0}};

  assign rs_nonzero_s = (fwd_rs_i != {REG_AW{1'b0}});
  assign skid_hit_s   = rs_nonzero_s & skid_valid_s & skid_s.regwrite & (skid_s.writereg == fwd_rs_i);
  assign main_hit_s   = rs_nonzero_s & main_valid_s & main_s.regwrite & (main_s.writereg == fwd_rs_i);

  // Forwarding: skid is the younger entry, so it wins over main.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = {DATA_W{1'b0}};
    if (skid_hit_s) begin
      fwd_hit_o  = 1'b1;
      fwd_data_o = select_result(skid_s);
    end else if (main_hit_s) begin
      fwd_hit_o  = 1'b1;
      fwd_data_o = select_result(main_s);
    end else begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = {DATA_W{1'b0}};
    end
  end

endmodule
